clock_display_scan: RTL and testbench

- Downstream consumer of the 12-hour timekeeping core.
- Snapshots binary hours/minutes/seconds/AM-PM on each second tick and converts each field to two BCD digits using a sequential double-dabble converter.
- Drives a 6-digit multiplexed 7-segment display (HH MM SS) with leading-zero blanking and AM/PM indication.
- Sits between the time counter and the board I/O pins.

---
 rtl/clock_display_pkg.sv | 56 +++++
 rtl/bin2bcd_seq.sv | 50 +++++
 rtl/clock_display_scan.sv | 203 ++++++++++++++++++++
 tb/tb_clock_display_scan.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/clock_display_pkg.sv
// Shared types, digit codes and segment lookup for the 12-hour clock display.
// Imported by the scan top and the BCD converter.
package clock_display_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV_H,
    S_CONV_M,
    S_CONV_S,
    S_COMMIT
  } state_t;

  typedef struct packed {
    logic [3:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       am_pm;
  } time_t;

  localparam int NUM_DIG = 6;
  localparam int DIG_HT  = 0;
  localparam int DIG_HU  = 1;
  localparam int DIG_MT  = 2;
  localparam int DIG_MU  = 3;
  localparam int DIG_ST  = 4;
  localparam int DIG_SU  = 5;

  localparam logic [3:0] CODE_BLANK = 4'hE;
  localparam logic [3:0] CODE_DASH  = 4'hF;

  // Segment order is {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg_lut(input logic [3:0] code);
    logic [6:0] s;
    unique case (code)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hF:    s = 7'h40;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  function automatic logic time_valid(input time_t t);
    return (t.hours != 4'd0) && (t.hours <= 4'd12) &&
           (t.minutes <= 6'd59) && (t.seconds <= 6'd59);
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 6-bit binary to two BCD digits.
// First iteration happens on the start edge so done lands 6 cycles later.
import clock_display_pkg::*;

module bin2bcd_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       start,
  input  logic [5:0] bin,
  output logic [3:0] tens,
  output logic [3:0] units,
  output logic       done
);

  logic [13:0] sr;
  logic [2:0]  cnt;

  function automatic logic [13:0] step(input logic [13:0] s);
    logic [3:0] t;
    logic [3:0] u;
    t = s[13:10];
    u = s[9:6];
    if (u >= 4'd5) u = u + 4'd3;
    if (t >= 4'd5) t = t + 4'd3;
    return {t, u, s[5:0]} << 1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      sr   <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else if (ena) begin
      done <= 1'b0;
      if (start) begin
        sr  <= step({8'd0, bin});
        cnt <= 3'd5;
      end else if (cnt != 3'd0) begin
        sr  <= step(sr);
        cnt <= cnt - 3'd1;
        if (cnt == 3'd1) done <= 1'b1;
      end
    end
  end

  assign tens  = sr[13:10];
  assign units = sr[9:6];

endmodule

// File: rtl/clock_display_scan.sv
// Snapshot, BCD conversion and 6-digit multiplexed scan for the clock.
// Optional blink of the field being set: CLOCK_DISPLAY_SCAN_BLINK_EN.
import clock_display_pkg::*;

module clock_display_scan #(
  parameter int SCAN_DIV  = 10000,
  parameter int BLINK_DIV = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       upd,
  input  logic [3:0] hours,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  input  logic       am_pm,
  input  logic [1:0] set_mode,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] dig_sel,
  output logic       busy,
  output logic       err
);

  localparam int PW = $clog2(SCAN_DIV + 1);

  state_t state, state_nx;
  time_t  in_t, snap, shadow;
  logic   pending, kick;

  logic [5:0] conv_bin;
  logic [3:0] conv_t, conv_u;
  logic       conv_done;

  logic [3:0] h_t, h_u, m_t, m_u, s_t, s_u;
  logic [5:0][3:0] disp;
  logic       disp_pm;

  logic [PW-1:0] presc;
  logic [2:0]    idx, idx_nx;
  logic          wrap, blank_nx, dp_raw;

  assign in_t = {hours, minutes, seconds, am_pm};

  bin2bcd_seq u_bcd (
    .clk   (clk),
    .rst   (rst),
    .ena   (ena),
    .start (kick),
    .bin   (conv_bin),
    .tens  (conv_t),
    .units (conv_u),
    .done  (conv_done)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else if (ena) state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:   if (upd) state_nx = S_CONV_H;
      S_CONV_H: if (conv_done) state_nx = S_CONV_M;
      S_CONV_M: if (conv_done) state_nx = S_CONV_S;
      S_CONV_S: if (conv_done) state_nx = S_COMMIT;
      S_COMMIT:
        state_nx = (upd || pending) ? S_CONV_H : S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != S_IDLE);
    conv_bin = 6'd0;
    unique case (state)
      S_CONV_H: conv_bin = {2'b00, snap.hours};
      S_CONV_M: conv_bin = snap.minutes;
      S_CONV_S: conv_bin = snap.seconds;
      default:  conv_bin = 6'd0;
    endcase
  end

  // kick is the start pulse in the first cycle of each conversion state
  always_ff @(posedge clk) begin
    if (rst) begin
      kick <= 1'b0;
    end else if (ena) begin
      kick <= (state_nx != state) &&
              (state_nx inside {S_CONV_H, S_CONV_M, S_CONV_S});
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      snap    <= '0;
      shadow  <= '0;
      pending <= 1'b0;
      h_t     <= '0;
      h_u     <= '0;
      m_t     <= '0;
      m_u     <= '0;
      s_t     <= '0;
      s_u     <= '0;
      disp    <= {NUM_DIG{CODE_BLANK}};
      disp_pm <= 1'b0;
      err     <= 1'b0;
    end else if (ena) begin
      if (state == S_IDLE && upd) snap <= in_t;
      if (busy && upd && state != S_COMMIT) begin
        shadow  <= in_t;
        pending <= 1'b1;
      end
      if (conv_done) begin
        unique case (state)
          S_CONV_H: begin h_t <= conv_t; h_u <= conv_u; end
          S_CONV_M: begin m_t <= conv_t; m_u <= conv_u; end
          S_CONV_S: begin s_t <= conv_t; s_u <= conv_u; end
          default: ;
        endcase
      end
      if (state == S_COMMIT) begin
        pending <= 1'b0;
        if (upd) snap <= in_t;
        else if (pending) snap <= shadow;
        disp_pm <= snap.am_pm;
        if (time_valid(snap)) begin
          err  <= 1'b0;
          disp <= {s_u, s_t, m_u, m_t, h_u,
                   (h_t == 4'd0) ? CODE_BLANK : h_t};
        end else begin
          err  <= 1'b1;
          disp <= {NUM_DIG{CODE_DASH}};
        end
      end
    end
  end

  assign wrap   = (presc == PW'(SCAN_DIV - 1));
  assign idx_nx = (idx == 3'(DIG_SU)) ? 3'd0 : idx + 3'd1;

  always_comb begin
    dp_raw = 1'b0;
    unique case (1'b1)
      idx_nx == 3'(DIG_HU),
      idx_nx == 3'(DIG_MU): dp_raw = 1'b1;
      idx_nx == 3'(DIG_SU): dp_raw = disp_pm;
      default:              dp_raw = 1'b0;
    endcase
  end

`ifdef CLOCK_DISPLAY_SCAN_BLINK_EN
  localparam int BW = $clog2(BLINK_DIV + 1);

  logic [BW-1:0] blink_cnt;
  logic          blink_ph;

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
    end else if (ena && wrap && idx == 3'(DIG_SU)) begin
      if (blink_cnt == BW'(BLINK_DIV - 1)) begin
        blink_cnt <= '0;
        blink_ph  <= ~blink_ph;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // digit pair n/2 belongs to set_mode n/2+1
  assign blank_nx = blink_ph && (set_mode != 2'd0) &&
                    (2'(idx_nx[2:1] + 2'd1) == set_mode);
`else
  logic unused_blink;
  assign unused_blink = ^set_mode ^ (BLINK_DIV == 0);
  assign blank_nx     = 1'b0;
`endif

  // select, segments and dp switch on the same edge to avoid ghosting
  always_ff @(posedge clk) begin
    if (rst) begin
      presc   <= '0;
      idx     <= '0;
      dig_sel <= 6'b000001;
      seg     <= '0;
      dp      <= 1'b0;
    end else if (ena) begin
      if (wrap) begin
        presc   <= '0;
        idx     <= idx_nx;
        dig_sel <= 6'(1) << idx_nx;
        seg     <= blank_nx ? 7'd0 : seg_lut(disp[idx_nx]);
        dp      <= blank_nx ? 1'b0 : dp_raw;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clock_display_scan.sv
// Directed bench for clock_display_scan: scan walk, conversion latency,
// pending update, range errors, mid-conversion reset and enable hold.
module tb_clock_display_scan;

  localparam int SD = 4;

  logic       clk = 1'b0;
  logic       rst, ena, upd, am_pm, dp, busy, err;
  logic [3:0] hours;
  logic [5:0] minutes, seconds, dig_sel;
  logic [1:0] set_mode;
  logic [6:0] seg;

  int checks = 0;
  int errors = 0;

  clock_display_scan #(.SCAN_DIV(SD), .BLINK_DIV(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .upd      (upd),
    .hours    (hours),
    .minutes  (minutes),
    .seconds  (seconds),
    .am_pm    (am_pm),
    .set_mode (set_mode),
    .seg      (seg),
    .dp       (dp),
    .dig_sel  (dig_sel),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic set_time(input logic [3:0] h, input logic [5:0] m,
                          input logic [5:0] s, input logic p);
    hours   = h;
    minutes = m;
    seconds = s;
    am_pm   = p;
    upd     = 1'b1;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  // wait for a fresh load of digit k so committed data is visible
  task automatic read_dig(input int k, output logic [6:0] s,
                          output logic d);
    logic [5:0] m;
    int n;
    m = 6'(1) << k;
    n = 0;
    while (dig_sel == m && n < 100) begin
      @(negedge clk);
      n++;
    end
    while (dig_sel != m && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("scan_timeout", n, 0);
    s = seg;
    d = dp;
  endtask

  task automatic check_frame(input string tag,
                             input logic [0:5][6:0] e,
                             input logic pm);
    logic [6:0] s;
    logic d;
    for (int k = 0; k < 6; k++) begin
      read_dig(k, s, d);
      chk($sformatf("%s_seg%0d", tag, k), s, e[k]);
      chk($sformatf("%s_dp%0d", tag, k), d,
          (k == 1 || k == 3 || (k == 5 && pm)));
    end
  endtask

  task automatic convert(input logic [3:0] h, input logic [5:0] m,
                         input logic [5:0] s, input logic p,
                         output int n);
    @(negedge clk);
    set_time(h, m, s, p);
    @(negedge clk);
    upd = 1'b0;
    wait_idle(n);
  endtask

  initial begin
    int n, n2;
    rst = 1'b1; ena = 1'b1; upd = 1'b0; set_mode = 2'd0;
    hours = '0; minutes = '0; seconds = '0; am_pm = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_seg", seg, 0);
    chk("rst_dp", dp, 0);
    chk("rst_sel", dig_sel, 6'b000001);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;

    // blank scan walk, one slot every SD cycles
    n = 0;
    while (dig_sel != 6'b000010 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("walk_first", dig_sel, 6'b000010);
    for (int j = 0; j < 6; j++) begin
      int k;
      k = (j + 2) % 6;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (dig_sel != (6'(1) << k) && n < 50);
      chk($sformatf("walk_len%0d", k), n, SD);
      chk($sformatf("walk_seg%0d", k), seg, 0);
      chk($sformatf("walk_dp%0d", k), dp, (k == 1 || k == 3));
    end

    convert(4'd9, 6'd5, 6'd47, 1'b1, n);
    chk("lat_busy", n, 22);
    chk("pm_err", err, 0);
    check_frame("pm", {7'h00, 7'h6F, 7'h3F, 7'h6D, 7'h66, 7'h07}, 1'b1);

    // second upd during conversion chains with no idle gap
    @(negedge clk);
    set_time(4'd12, 6'd59, 6'd59, 1'b0);
    @(negedge clk);
    upd = 1'b0;
    n = 0;
    repeat (4) begin
      n += int'(busy);
      @(negedge clk);
    end
    set_time(4'd1, 6'd0, 6'd0, 1'b0);
    n += int'(busy);
    @(negedge clk);
    upd = 1'b0;
    wait_idle(n2);
    chk("pend_busy", n + n2, 44);
    check_frame("pend", {7'h00, 7'h06, 7'h3F, 7'h3F, 7'h3F, 7'h3F}, 1'b0);

    convert(4'd0, 6'd10, 6'd10, 1'b0, n);
    chk("h0_err", err, 1);
    check_frame("h0", {6{7'h40}}, 1'b0);

    convert(4'd3, 6'd21, 6'd10, 1'b1, n);
    chk("clr_err", err, 0);
    check_frame("clr", {7'h00, 7'h4F, 7'h5B, 7'h06, 7'h06, 7'h3F}, 1'b1);

    convert(4'd5, 6'd60, 6'd0, 1'b0, n);
    chk("m60_err", err, 1);
    check_frame("m60", {6{7'h40}}, 1'b0);

    // reset in cycle 10 of a conversion
    @(negedge clk);
    set_time(4'd7, 6'd30, 6'd15, 1'b1);
    @(negedge clk);
    upd = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_seg", seg, 0);
    chk("mrst_dp", dp, 0);
    chk("mrst_sel", dig_sel, 6'b000001);
    chk("mrst_busy", busy, 0);
    chk("mrst_err", err, 0);

    // enable low freezes scan and ignores upd
    ena = 1'b0;
    set_time(4'd8, 6'd8, 6'd8, 1'b0);
    @(negedge clk);
    upd = 1'b0;
    repeat (3 * SD + 5) @(negedge clk);
    chk("ena_sel", dig_sel, 6'b000001);
    chk("ena_busy", busy, 0);
    chk("ena_seg", seg, 0);
    ena = 1'b1;
    @(negedge clk);
    chk("ena_busy2", busy, 0);
    check_frame("mrst", {6{7'h00}}, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
